gpio_in_filter: RTL and testbench

GPIO input conditioner between the padring data-from-pad outputs (`*_din`) and the SoC `gpio_i` bus in the ASIC top level. It does three things:
- synchronizes asynchronous pad inputs into the `clk_i` domain;
- applies an optional per-pin glitch filter with a programmable stability threshold;
- reports filtered level changes through a valid/ready event port, lowest pin first.

The event port feeds the SoC interrupt and event logic.

---
 rtl/gpio_in_filter.sv | 149 ++++++++++++++
 tb/tb_gpio_in_filter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_in_filter.sv
// GPIO input conditioner: pad synchronizer, per-pin glitch filter, edge pulses and a
// lowest-pin-first valid/ready change reporter.
module gpio_in_filter #(
   parameter int unsigned NumPins    = 32,
   parameter int unsigned SyncStages = 2,
   parameter int unsigned CntWidth   = 8,
   localparam int unsigned PinW      = $clog2(NumPins)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [NumPins-1:0]  pad_din_i,
   input  logic [NumPins-1:0]  filt_en_i,
   input  logic [CntWidth-1:0] filt_thresh_i,
   output logic [NumPins-1:0]  gpio_o,
   output logic [NumPins-1:0]  rise_o,
   output logic [NumPins-1:0]  fall_o,
   output logic                evt_valid_o,
   input  logic                evt_ready_i,
   output logic [PinW-1:0]     evt_pin_o,
   output logic                evt_level_o,
   output logic                evt_lost_o,
   input  logic                evt_lost_clr_i
);

   typedef enum logic {StIdle, StHold} state_e;

   logic [NumPins-1:0]  sync_q [SyncStages];
   logic [NumPins-1:0]  sync_s;
   logic [CntWidth-1:0] cnt_q  [NumPins];
   logic [CntWidth-1:0] cnt_d  [NumPins];
   logic [NumPins-1:0]  gpio_q, gpio_d;
   logic [NumPins-1:0]  rise_q, fall_q;
   logic [NumPins-1:0]  pend_q, pend_d;
   logic [NumPins-1:0]  chg, clr_mask;
   logic                lost_q, lost_d;
   state_e              state_q, state_d;
   logic [PinW-1:0]     pin_q, pin_d;
   logic                level_q, level_d;
   logic [PinW-1:0]     pick_idx;
   logic                pend_any;

   assign sync_s = sync_q[SyncStages-1];

   // Glitch filter: a change is accepted once the counter has reached the threshold.
   always_comb begin
      gpio_d = gpio_q;
      for (int i = 0; i < NumPins; i++) begin
         cnt_d[i] = '0;
         if (!filt_en_i[i]) begin
            gpio_d[i] = sync_s[i];
         end else if (sync_s[i] != gpio_q[i]) begin
            if (cnt_q[i] >= filt_thresh_i) begin
               gpio_d[i] = sync_s[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CntWidth'(1);
            end
         end
      end
   end

   assign chg = gpio_d ^ gpio_q;

   always_comb begin
      pick_idx = '0;
      pend_any = |pend_q;
      for (int i = NumPins - 1; i >= 0; i--) begin
         if (pend_q[i]) begin
            pick_idx = PinW'(i);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      pin_d    = pin_q;
      level_d  = level_q;
      clr_mask = '0;
      case (state_q)
         StIdle: begin
            if (pend_any) begin
               pin_d              = pick_idx;
               level_d            = gpio_q[pick_idx];
               clr_mask[pick_idx] = 1'b1;
               state_d            = StHold;
            end
         end
         StHold: begin
            if (evt_ready_i) begin
               if (pend_any) begin
                  pin_d              = pick_idx;
                  level_d            = gpio_q[pick_idx];
                  clr_mask[pick_idx] = 1'b1;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // A new change wins over the capture clear of the same bit.
   assign pend_d = (pend_q & ~clr_mask) | chg;
   assign lost_d = (|(chg & pend_q & ~clr_mask)) | (lost_q & ~evt_lost_clr_i);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int k = 0; k < SyncStages; k++) begin
            sync_q[k] <= '0;
         end
         for (int i = 0; i < NumPins; i++) begin
            cnt_q[i] <= '0;
         end
         gpio_q  <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
         pend_q  <= '0;
         lost_q  <= 1'b0;
         state_q <= StIdle;
         pin_q   <= '0;
         level_q <= 1'b0;
      end else begin
         sync_q[0] <= pad_din_i;
         for (int k = 1; k < SyncStages; k++) begin
            sync_q[k] <= sync_q[k-1];
         end
         for (int i = 0; i < NumPins; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         gpio_q  <= gpio_d;
         rise_q  <= gpio_d & ~gpio_q;
         fall_q  <= ~gpio_d & gpio_q;
         pend_q  <= pend_d;
         lost_q  <= lost_d;
         state_q <= state_d;
         pin_q   <= pin_d;
         level_q <= level_d;
      end
   end

   assign gpio_o      = gpio_q;
   assign rise_o      = rise_q;
   assign fall_o      = fall_q;
   assign evt_valid_o = (state_q == StHold);
   assign evt_pin_o   = pin_q;
   assign evt_level_o = level_q;
   assign evt_lost_o  = lost_q;

endmodule

// File: tb/tb_gpio_in_filter.sv
// Directed bench for gpio_in_filter: a behavioural model checked every cycle plus
// hand-computed expectations at the key points of each scenario.
module tb_gpio_in_filter;

   localparam int NP = 32;
   localparam int SS = 2;

   logic          clk;
   logic          rst_n;
   logic [NP-1:0] pad;
   logic [NP-1:0] en;
   logic [7:0]    thresh;
   logic          ready;
   logic          clr;
   logic [NP-1:0] gpio;
   logic [NP-1:0] rise;
   logic [NP-1:0] fall;
   logic          valid;
   logic [4:0]    pin;
   logic          level;
   logic          lost;

   int tests = 0;
   int fails = 0;

   gpio_in_filter #(
      .NumPins   (NP),
      .SyncStages(SS),
      .CntWidth  (8)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .pad_din_i     (pad),
      .filt_en_i     (en),
      .filt_thresh_i (thresh),
      .gpio_o        (gpio),
      .rise_o        (rise),
      .fall_o        (fall),
      .evt_valid_o   (valid),
      .evt_ready_i   (ready),
      .evt_pin_o     (pin),
      .evt_level_o   (level),
      .evt_lost_o    (lost),
      .evt_lost_clr_i(clr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: pad history gives the synchronized value; a run length of
   // differing cycles decides acceptance; pending set plus held event for reporting.
   logic [NP-1:0] hist[$];
   logic [NP-1:0] m_lvl, m_rise, m_fall, m_pend;
   bit            m_hold, m_level, m_lost, m_ok;
   int            m_pin;
   int            run[NP];

   initial m_ok = 1'b0;

   always @(posedge clk) begin
      logic [NP-1:0] s, new_lvl, chg, taken;
      if (!rst_n) begin
         hist = {};
         for (int k = 0; k < SS; k++) hist.push_front('0);
         m_lvl = '0; m_rise = '0; m_fall = '0; m_pend = '0;
         m_hold = 1'b0; m_level = 1'b0; m_lost = 1'b0; m_pin = 0;
         for (int i = 0; i < NP; i++) run[i] = 0;
         m_ok = 1'b1;
      end else if (m_ok) begin
         hist.push_front(pad);
         s = hist[SS];
         void'(hist.pop_back());
         new_lvl = m_lvl;
         for (int i = 0; i < NP; i++) begin
            if (!en[i]) begin
               new_lvl[i] = s[i];
               run[i] = 0;
            end else if (s[i] == m_lvl[i]) begin
               run[i] = 0;
            end else begin
               run[i]++;
               if (run[i] > int'(thresh)) begin
                  new_lvl[i] = s[i];
                  run[i] = 0;
               end
            end
         end
         chg   = new_lvl ^ m_lvl;
         taken = '0;
         if (!m_hold || ready) begin
            if (m_pend != 0) begin
               for (int j = NP - 1; j >= 0; j--) if (m_pend[j]) m_pin = j;
               m_level = m_lvl[m_pin];
               taken[m_pin] = 1'b1;
               m_hold = 1'b1;
            end else begin
               m_hold = 1'b0;
            end
         end
         m_lost = (|(chg & m_pend & ~taken)) | (m_lost & !clr);
         m_pend = (m_pend & ~taken) | chg;
         m_rise = new_lvl & ~m_lvl;
         m_fall = ~new_lvl & m_lvl;
         m_lvl  = new_lvl;
      end
   end

   always @(negedge clk) begin
      if (m_ok) begin
         chk("m_gpio",  gpio,       m_lvl);
         chk("m_rise",  rise,       m_rise);
         chk("m_fall",  fall,       m_fall);
         chk("m_valid", 32'(valid), 32'(m_hold));
         chk("m_pin",   32'(pin),   32'(m_pin));
         chk("m_level", 32'(level), 32'(m_level));
         chk("m_lost",  32'(lost),  32'(m_lost));
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; pad = '0; en = '0; thresh = '0; ready = 1'b0; clr = 1'b0;
      step(2);
      chk("rst_gpio",  gpio,        32'h0);
      chk("rst_valid", 32'(valid),  32'h0);
      chk("rst_lost",  32'(lost),   32'h0);
      rst_n = 1'b1;

      // Latency, filter off
      pad[3] = 1'b1;
      step(2);
      chk("lat_gpio_early", 32'(gpio[3]), 32'h0);
      step(1);
      chk("lat_gpio",  32'(gpio[3]), 32'h1);
      chk("lat_rise",  32'(rise[3]), 32'h1);
      step(1);
      chk("lat_valid", 32'(valid),   32'h1);
      chk("lat_pin",   32'(pin),     32'd3);
      chk("lat_level", 32'(level),   32'h1);
      chk("lat_rise_gone", 32'(rise[3]), 32'h0);
      ready = 1'b1;
      step(1);
      chk("lat_accept", 32'(valid), 32'h0);
      ready = 1'b0;

      // Glitch rejection, thresh 3 on pin 7
      thresh = 8'd3; en[7] = 1'b1;
      pad[7] = 1'b1;
      step(3);
      pad[7] = 1'b0;
      step(8);
      chk("glitch_gpio",  32'(gpio[7]), 32'h0);
      chk("glitch_valid", 32'(valid),   32'h0);
      pad[7] = 1'b1;
      step(4);
      pad[7] = 1'b0;
      step(1);
      chk("pulse4_early", 32'(gpio[7]), 32'h0);
      step(1);
      chk("pulse4_gpio", 32'(gpio[7]), 32'h1);
      chk("pulse4_rise", 32'(rise[7]), 32'h1);
      step(1);
      chk("pulse4_pin",  32'(pin),     32'd7);
      ready = 1'b1;
      step(12);
      ready = 1'b0;
      chk("pulse4_drain", 32'(valid),  32'h0);
      chk("pulse4_low",   32'(gpio[7]), 32'h0);

      // Priority and held-event stability
      pad[5] = 1'b1; pad[2] = 1'b1;
      step(4);
      chk("prio_valid", 32'(valid), 32'h1);
      chk("prio_pin",   32'(pin),   32'd2);
      pad[0] = 1'b1;
      step(4);
      chk("prio_held",  32'(pin),   32'd2);
      ready = 1'b1;
      step(1);
      chk("prio_pin0",  32'(pin),   32'd0);
      step(1);
      chk("prio_pin5",  32'(pin),   32'd5);
      step(1);
      chk("prio_done",  32'(valid), 32'h0);
      ready = 1'b0;

      // Lost event: pin 1 occupies the port while pin 9 toggles twice
      pad[1] = 1'b1;
      step(4);
      chk("lost_hold_pin", 32'(pin), 32'd1);
      pad[9] = 1'b1;
      step(2);
      pad[9] = 1'b0;
      step(4);
      chk("lost_set",  32'(lost),    32'h1);
      ready = 1'b1;
      step(1);
      chk("lost_pin",   32'(pin),   32'd9);
      chk("lost_level", 32'(level), 32'h0);
      step(1);
      chk("lost_done",  32'(valid), 32'h0);
      ready = 1'b0;
      clr = 1'b1;
      step(1);
      clr = 1'b0;
      chk("lost_clr",   32'(lost),  32'h0);

      // Set/clear collision on pin 4
      pad[4] = 1'b1;
      step(1);
      pad[4] = 1'b0;
      step(4);
      chk("coll_pin1",   32'(pin),   32'd4);
      chk("coll_level1", 32'(level), 32'h1);
      chk("coll_nolost", 32'(lost),  32'h0);
      ready = 1'b1;
      step(1);
      chk("coll_valid2", 32'(valid), 32'h1);
      chk("coll_pin2",   32'(pin),   32'd4);
      chk("coll_level2", 32'(level), 32'h0);
      step(1);
      chk("coll_done",   32'(valid), 32'h0);
      ready = 1'b0;

      // Reset during HOLD with pin 7 half counted
      pad[1] = 1'b0;
      step(4);
      chk("rmo_hold", 32'(valid), 32'h1);
      pad[7] = 1'b1;
      step(4);
      rst_n = 1'b0;
      step(1);
      chk("rmo_gpio",  gpio,       32'h0);
      chk("rmo_rise",  rise,       32'h0);
      chk("rmo_valid", 32'(valid), 32'h0);
      chk("rmo_pin",   32'(pin),   32'h0);
      rst_n = 1'b1;
      step(2);
      chk("rmo_gpio_fill", gpio,       32'h0);
      chk("rmo_no_stale",  32'(valid), 32'h0);
      step(1);
      chk("rmo_gpio_unf",  gpio,       32'h0000_002D);
      step(3);
      chk("rmo_gpio_filt", gpio,       32'h0000_00AD);
      ready = 1'b1;
      step(8);
      chk("rmo_drain", 32'(valid), 32'h0);
      ready = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
